// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between an upstream FIFO and the UART transmitter.
// master: the transmitter (issues read strobes, consumes data).
// slave:  the FIFO (presents empty flag and data).
interface fifo_uart_tx_if;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_read_en;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_read_en
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_read_en
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART 8N1 transmitter fed from a FIFO read port.
// Pulls one byte per frame (FETCH strobe, data captured one cycle later in
// LOAD), then shifts it out LSB first between a start and a stop bit.
// All outputs are decoded from registered state only.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic           read_clk,
    input  logic           reset,
    input  logic           tx_enable,
    fifo_uart_tx_if.master fifo,
    output logic           tx,
    output logic           busy,
    output logic           frame_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          bit_end;

    // Last cycle of the current bit period; the counter restarts from 0
    // here so it can never wrap inside a bit.
    assign bit_end = (cnt_q == CNT_LAST);

    // State, baud counter, bit index and shift register.
    always_ff @(posedge read_clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic; inputs are only looked at in IDLE, so a frame in
    // flight ignores tx_enable / fifo_empty until it has finished.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (tx_enable && !fifo.fifo_empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                cnt_d   = '0;
                state_d = LOAD;
            end
            LOAD: begin
                shift_d = fifo.fifo_data;
                bit_d   = '0;
                cnt_d   = '0;
                state_d = START;
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state; line idles high.
    always_comb begin
        tx                = 1'b1;
        fifo.fifo_read_en = 1'b0;
        frame_done        = 1'b0;
        busy              = (state_q != IDLE);
        case (state_q)
            FETCH: fifo.fifo_read_en = 1'b1;
            START: tx = 1'b0;
            DATA:  tx = shift_q[0];
            STOP:  frame_done = bit_end;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx. A FIFO stub feeds bytes; a frame model turns each
// started frame into a per-cycle script of expected {tx, read_en, frame_done}
// and every cycle is checked against it, plus literal frame/timing checks.
module tb_fifo_uart_tx;

    localparam int CPB  = 4;
    localparam int NREC = 300;

    logic read_clk = 1'b0;
    logic reset    = 1'b0;
    logic tx_enable = 1'b0;
    logic tx, busy, frame_done;

    fifo_uart_tx_if fif();

    always #5 read_clk = ~read_clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .read_clk   (read_clk),
        .reset      (reset),
        .tx_enable  (tx_enable),
        .fifo       (fif),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // FIFO stub: data appears the cycle after the read strobe.
    logic [7:0] mem [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fif.fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge read_clk) begin
        if (fif.fifo_read_en) begin
            fif.fifo_data <= mem[rd_ptr % 16];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    // Frame model: script[0] is the expectation {tx, rd, done} for the
    // current cycle; an empty script means idle.
    logic [2:0] script [$];
    always @(posedge read_clk or negedge reset) begin
        if (!reset) begin
            script.delete();
        end else if (script.size() > 0) begin
            script.delete(0);
        end else if (tx_enable && (wr_ptr != rd_ptr)) begin
            logic [7:0] b;
            logic       lvl;
            b = mem[rd_ptr % 16];
            script.push_back(3'b110);               // read strobe cycle
            script.push_back(3'b100);               // data capture cycle
            for (int p = 0; p < 10; p++) begin
                lvl = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : b[p-1];
                for (int c = 0; c < CPB; c++)
                    script.push_back({lvl, 1'b0, (p == 9 && c == CPB - 1)});
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: compare outputs against the model, then leave room to drive.
    task automatic tick();
        logic [2:0] e;
        logic       eb;
        @(negedge read_clk);
        eb = (script.size() > 0);
        e  = eb ? script[0] : 3'b100;
        chk("cyc_tx",   {31'd0, tx},               {31'd0, e[2]});
        chk("cyc_rd",   {31'd0, fif.fifo_read_en}, {31'd0, e[1]});
        chk("cyc_done", {31'd0, frame_done},       {31'd0, e[0]});
        chk("cyc_busy", {31'd0, busy},             {31'd0, eb});
        #2;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 16] = b;
        wr_ptr++;
    endtask

    // Recording of a measurement window.
    bit txa [NREC];
    bit rda [NREC];
    bit dna [NREC];
    int n_rd, n_done, n_busy, n_low, m_s;

    // Runs n cycles; drop_at / rst_at are offsets from the first tx fall.
    task automatic measure(input int n, input int drop_at, input int rst_at);
        int s;
        s = -1;
        n_rd = 0; n_done = 0; n_busy = 0; n_low = 0;
        for (int k = 0; k < NREC; k++) begin
            txa[k] = 1'b1; rda[k] = 1'b0; dna[k] = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            tick();
            txa[i] = tx; rda[i] = fif.fifo_read_en; dna[i] = frame_done;
            n_rd   += int'(fif.fifo_read_en);
            n_done += int'(frame_done);
            n_busy += int'(busy);
            n_low  += int'(!tx);
            if (s < 0 && tx == 1'b0) s = i;
            if (s >= 0 && drop_at >= 0 && i == s + drop_at) tx_enable = 1'b0;
            if (s >= 0 && rst_at >= 0 && i == s + rst_at) begin
                reset = 1'b0;
                #1;
                chk("rst_tx_high",  {31'd0, tx},         32'd1);
                chk("rst_busy_low", {31'd0, busy},       32'd0);
                chk("rst_no_done",  {31'd0, frame_done}, 32'd0);
            end
            if (s >= 0 && rst_at >= 0 && i == s + rst_at + 3) reset = 1'b1;
        end
        m_s = s;
    endtask

    function automatic int find_fall(input int from);
        for (int i = (from < 1 ? 1 : from); i < NREC; i++)
            if (txa[i] == 1'b0 && txa[i-1] == 1'b1) return i;
        return -1000;
    endfunction

    function automatic int find_rd(input int from);
        for (int i = from; i < NREC; i++)
            if (rda[i]) return i;
        return -1000;
    endfunction

    function automatic int find_done(input int from);
        for (int i = from; i < NREC; i++)
            if (dna[i]) return i;
        return -1000;
    endfunction

    // Frame bits sampled mid-bit: [0]=start, [8:1]=data, [9]=stop.
    function automatic logic [9:0] frame_at(input int s);
        logic [9:0] f;
        f = '1;
        if (s < 0 || s + CPB * 10 >= NREC) return 10'h000;
        for (int p = 0; p < 10; p++) f[p] = txa[s + CPB * p + CPB / 2];
        return f;
    endfunction

    initial begin
        int s, r, d, f2;

        // Reset held with data available and permission given.
        reset = 1'b0;
        push(8'hCA);
        tx_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("reset_tx",   {31'd0, tx},               32'd1);
            chk("reset_busy", {31'd0, busy},             32'd0);
            chk("reset_rd",   {31'd0, fif.fifo_read_en}, 32'd0);
        end
        tx_enable = 1'b0;
        reset = 1'b1;
        tick(); tick();
        chk("reset_no_pop", rd_ptr, 32'd0);

        // Single byte 0xCA.
        tx_enable = 1'b1;
        measure(60, -1, -1);
        s = find_fall(1);
        r = find_rd(0);
        d = find_done(0);
        chk("ca_frame",    {22'd0, frame_at(s)}, {22'd0, 10'b1110010100});
        chk("ca_rd_cnt",   n_rd,   32'd1);
        chk("ca_done_cnt", n_done, 32'd1);
        chk("ca_busy_len", n_busy, 32'd42);
        chk("ca_rd_to_fall", s - r, 32'd2);
        chk("ca_done_pos", d - s, 32'd39);

        // Empty gating.
        measure(100, -1, -1);
        chk("empty_rd",   n_rd,   32'd0);
        chk("empty_busy", n_busy, 32'd0);
        chk("empty_low",  n_low,  32'd0);

        // Back-to-back 0xAA, 0x55.
        tx_enable = 1'b0;
        tick();
        push(8'hAA);
        push(8'h55);
        tx_enable = 1'b1;
        measure(110, -1, -1);
        s  = find_fall(1);
        d  = find_done(0);
        f2 = find_fall(d + 1);
        chk("b2b_frame1",   {22'd0, frame_at(s)},  {22'd0, 10'b1101010100});
        chk("b2b_frame2",   {22'd0, frame_at(f2)}, {22'd0, 10'b1010101010});
        chk("b2b_rd_cnt",   n_rd,   32'd2);
        chk("b2b_done_cnt", n_done, 32'd2);
        chk("b2b_gap",      f2 - d - 1, 32'd3);

        // tx_enable dropped during data bit 3 of 0x0F.
        tx_enable = 1'b0;
        tick();
        push(8'h0F);
        push(8'h33);
        tx_enable = 1'b1;
        measure(100, 17, -1);
        s = find_fall(1);
        chk("drop_frame",    {22'd0, frame_at(s)}, {22'd0, 10'b1000011110});
        chk("drop_rd_cnt",   n_rd,   32'd1);
        chk("drop_done_cnt", n_done, 32'd1);
        chk("drop_left",     wr_ptr - rd_ptr, 32'd1);

        // Reset during data bit 5 of 0x33, then a fresh 0x3C frame.
        push(8'h3C);
        tx_enable = 1'b1;
        measure(120, -1, 25);
        r  = find_rd(m_s + 1);
        f2 = find_fall(m_s + 26);
        chk("rst_done_cnt", n_done, 32'd1);
        chk("rst_rd_cnt",   n_rd,   32'd2);
        chk("rst_rd_pos",   r - m_s,  32'd29);
        chk("rst_fall_pos", f2 - m_s, 32'd31);
        chk("rst_frame2",   {22'd0, frame_at(f2)}, {22'd0, 10'b1001111000});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
